// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared constants and types for the PWM LED driver.
//   DUTY_W     : duty value width (8 bits, 0..255)
//   PERIOD_MAX : last period counter value before wrap (period = 255 ticks)
//   duty_t     : duty value type
//   wr_t       : per-channel shadow write request
package pwm_pkg;
   localparam int DUTY_W     = 8;
   localparam int PERIOD_MAX = 254;

   typedef logic [DUTY_W-1:0] duty_t;

   typedef struct packed {
      logic  en;
      duty_t value;
   } wr_t;
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler -- divides clk into a one-cycle tick every PRESCALE cycles.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (count returns to 0)
//   tick : high for one clk every PRESCALE clk cycles
// With PRESCALE=1 the count register never leaves 0, so tick is constant 1
// and synthesis reduces the counter to a constant.
module pwm_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pcnt;

   assign tick = (pcnt == LAST);

   always_ff @(posedge clk) begin
      if (rst)       pcnt <= '0;
      else if (tick) pcnt <= '0;
      else           pcnt <= pcnt + PW'(1);
   end
endmodule

// File: rtl/pwm_driver.sv
// pwm_driver -- multi-channel 8-bit PWM with double-buffered duty registers.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   duty_valid   : duty write offered
//   duty_ready   : duty write accepted this cycle (low on commit cycle and in reset)
//   duty_chan    : target channel; indices >= CHANNELS are accepted and dropped
//   duty_value   : duty 0..255 (high for duty of 255 ticks)
//   pwm_out      : per-channel PWM waveform
//   period_start : one-clk pulse with the first pwm_out sample of each period
// Build option: PWM_DRIVER_ACTIVE_LOW_EN inverts pwm_out (inactive level 1);
// all timing is identical in both builds.
module pwm_driver
   import pwm_pkg::*;
#(
   parameter  int CHANNELS = 3,
   parameter  int PRESCALE = 1,
   localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                duty_valid,
   output logic                duty_ready,
   input  logic [CW-1:0]       duty_chan,
   input  logic [DUTY_W-1:0]   duty_value,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_start
);
   localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD_MAX);
   localparam logic [CW:0]       CH_LIM   = (CW+1)'(CHANNELS);

   logic                tick;
   logic                commit;
   logic                accept;
   logic [DUTY_W-1:0]   cnt;
   logic [CHANNELS-1:0] pwm_q;
   logic [CHANNELS-1:0] pwm_act;
   // commit -> counter at 0 -> first registered compare of the new period
   logic [1:0]          vld_pipe;

   pwm_prescaler #(.PRESCALE(PRESCALE)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign commit     = tick && (cnt == CNT_LAST);
   assign duty_ready = !rst && !commit;
   assign accept     = duty_valid && duty_ready && ({1'b0, duty_chan} < CH_LIM);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         vld_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[0], commit};
         if (tick) cnt <= commit ? '0 : cnt + DUTY_W'(1);
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      wr_t   req;
      duty_t shd;
      duty_t act;
      logic  q;

      assign req.en    = accept && (duty_chan == CW'(i));
      assign req.value = duty_value;
      assign pwm_q[i]  = q;

      // A write can never land on the commit cycle (ready is low), so the
      // shadow and active updates need no priority between them.
      always_ff @(posedge clk) begin
         if (rst) begin
            shd <= '0;
            act <= '0;
            q   <= 1'b0;
         end else begin
            if (req.en) shd <= req.value;
            if (commit) act <= shd;
            q <= (cnt < act);
         end
      end
   end

   // Masking with rst makes the outputs inactive from the very first reset
   // cycle instead of one clk later.
   assign pwm_act      = rst ? '0 : pwm_q;
   assign period_start = !rst && vld_pipe[1];

`ifdef PWM_DRIVER_ACTIVE_LOW_EN
   assign pwm_out = ~pwm_act;
`else
   assign pwm_out = pwm_act;
`endif
endmodule

// File: tb/tb_pwm_driver.sv
module tb_pwm_driver;
   logic       clk = 1'b0;
   logic       rst, duty_valid, duty_ready, period_start;
   logic [1:0] duty_chan;
   logic [7:0] duty_value;
   logic [2:0] pwm_out;

   logic       rst4, v4, rdy4, ps4;
   logic [1:0] c4;
   logic [7:0] d4;
   logic [2:0] pwm4;

`ifdef PWM_DRIVER_ACTIVE_LOW_EN
   localparam logic [2:0] INV = 3'b111;
`else
   localparam logic [2:0] INV = 3'b000;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pwm_driver #(.CHANNELS(3), .PRESCALE(1)) u_dut (
      .clk(clk), .rst(rst), .duty_valid(duty_valid), .duty_ready(duty_ready),
      .duty_chan(duty_chan), .duty_value(duty_value), .pwm_out(pwm_out),
      .period_start(period_start)
   );

   pwm_driver #(.CHANNELS(3), .PRESCALE(4)) u_dut4 (
      .clk(clk), .rst(rst4), .duty_valid(v4), .duty_ready(rdy4),
      .duty_chan(c4), .duty_value(d4), .pwm_out(pwm4), .period_start(ps4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] ch, input logic [7:0] val);
      duty_valid = 1'b1; duty_chan = ch; duty_value = val;
      step();
      duty_valid = 1'b0;
   endtask

   // window results (one 255-cycle period starting at a period_start cycle)
   int         hi [3];
   int         tr [3];
   logic [2:0] first;
   int         ps_n, rdy_lo_n, rdy_lo_at, acc_at;

   task automatic measure(input int wr_at, input logic [1:0] wch, input logic [7:0] wval);
      logic [2:0] p, prev;
      logic       acc;
      for (int c = 0; c < 3; c++) begin hi[c] = 0; tr[c] = 0; end
      ps_n = 0; rdy_lo_n = 0; rdy_lo_at = -1; acc_at = -1; prev = '0;
      for (int i = 0; i < 255; i++) begin
         if (i == wr_at) begin
            duty_valid = 1'b1; duty_chan = wch; duty_value = wval;
            #1;
         end
         p = pwm_out ^ INV;
         if (i == 0) first = p;
         for (int c = 0; c < 3; c++) begin
            if (p[c]) hi[c]++;
            if (i > 0 && p[c] != prev[c]) tr[c]++;
         end
         prev = p;
         if (period_start) ps_n++;
         if (!duty_ready) begin rdy_lo_n++; rdy_lo_at = i; end
         acc = duty_valid && duty_ready;
         if (acc) acc_at = i;
         step();
         if (acc) duty_valid = 1'b0;
      end
      chk("ps_next", period_start, 1);
      chk("win_ps_n", ps_n, 1);
      chk("win_rdy_lo_n", rdy_lo_n, 1);
      chk("win_rdy_lo_at", rdy_lo_at, 253);
   endtask

   task automatic wait_ps(input int limit, output int n, output logic [2:0] pre);
      n = 0; pre = '0;
      while (!period_start && n < limit) begin
         pre = pre | (pwm_out ^ INV);
         step();
         n++;
      end
   endtask

   initial begin
      int         n, h;
      logic [2:0] pre;
      logic       f4, s4;
      rst = 1'b1; duty_valid = 1'b0; duty_chan = '0; duty_value = '0;
      rst4 = 1'b1; v4 = 1'b0; c4 = '0; d4 = '0;
      repeat (3) step();
      chk("rst_pin", pwm_out, INV);
      chk("rst_rdy", duty_ready, 0);
      chk("rst_ps", period_start, 0);
      rst = 1'b0;
      #1;
      chk("rel_rdy", duty_ready, 1);
      chk("rel_pin", pwm_out, INV);

      // ch0=0, ch1=255, ch2=64; period 1 stays dark, period 2 uses them
      wr(2'd0, 8'd0);
      wr(2'd1, 8'd255);
      wr(2'd2, 8'd64);
      wait_ps(600, n, pre);
      chk("ps_wait", n, 253);
      chk("p1_dark", pre, 0);
      measure(-1, 2'd0, 8'd0);
      chk("p2_ch0_hi", hi[0], 0);
      chk("p2_ch1_hi", hi[1], 255);
      chk("p2_ch2_hi", hi[2], 64);
      chk("p2_ch2_first", first[2], 1);
      chk("p2_ch2_edges", tr[2], 1);

      // ch1=10 committed, then ch1=128 written mid-period at counter 100
      measure(5, 2'd1, 8'd10);
      chk("p3_ch1_hi", hi[1], 255);
      chk("p3_acc", acc_at, 5);
      measure(99, 2'd1, 8'd128);
      chk("p4_ch1_hi", hi[1], 10);
      chk("p4_acc", acc_at, 99);

      // write offered on the commit cycle completes one clk later
      measure(253, 2'd0, 8'd200);
      chk("p5_ch1_hi", hi[1], 128);
      chk("p5_ch1_first", first[1], 1);
      chk("p5_acc", acc_at, 254);
      measure(-1, 2'd0, 8'd0);
      chk("p6_ch0_hi", hi[0], 0);
      measure(-1, 2'd0, 8'd0);
      chk("p7_ch0_hi", hi[0], 200);
      chk("p7_ch2_hi", hi[2], 64);

      // 1-clk reset at counter 180
      repeat (179) step();
      rst = 1'b1;
      #1;
      chk("mid_rst_rdy", duty_ready, 0);
      chk("mid_rst_pin", pwm_out, INV);
      chk("mid_rst_ps", period_start, 0);
      step();
      rst = 1'b0;
      #1;
      chk("mid_rel_rdy", duty_ready, 1);
      chk("mid_rel_pin", pwm_out, INV);
      wait_ps(600, n, pre);
      chk("mid_ps_wait", n, 256);
      chk("mid_dark", pre, 0);
      measure(-1, 2'd0, 8'd0);
      chk("mid_p_hi0", hi[0], 0);
      chk("mid_p_hi1", hi[1], 0);
      chk("mid_p_hi2", hi[2], 0);

      // PRESCALE=4, ch0=1
      rst4 = 1'b0; v4 = 1'b1; c4 = 2'd0; d4 = 8'd1;
      #1;
      chk("p4_rel_rdy", rdy4, 1);
      step();
      v4 = 1'b0;
      n = 0;
      while (!ps4 && n < 3000) begin step(); n++; end
      chk("p4_ps_wait", n, 1020);
      f4 = pwm4[0] ^ INV[0];
      s4 = 1'b1;
      h = 0; n = 0;
      do begin
         if (pwm4[0] ^ INV[0]) h++;
         if (n == 4) s4 = pwm4[0] ^ INV[0];
         step();
         n++;
      end while (!ps4 && n < 2000);
      chk("p4_ps_gap", n, 1020);
      chk("p4_ch0_hi", h, 4);
      chk("p4_ch0_first", f4, 1);
      chk("p4_ch0_off4", s4, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
